// File: rtl/mult_seq_param.sv
// Sequential add-shift multiplier (signed/unsigned) with its own control FSM.
// The product builds up in {A,B}; X carries the extension bit (sign or carry).
module mult_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] S,
  input  logic             load_b,
  input  logic             start,
  input  logic             signed_en,
  output logic             X,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  if (WIDTH < 2) begin : g_width_check
    $error("mult_seq_param: WIDTH must be at least 2");
  end

  state_t           state_q, state_d;
  logic             x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;

  logic [WIDTH:0]   ext;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             lastStep;

  // The MSB of a two's-complement multiplier carries negative weight, so the final step subtracts.
  assign ext      = mode_q ? {S[WIDTH-1], S} : {1'b0, S};
  assign acc      = {x_q, a_q};
  assign sum      = acc + ext;
  assign diff     = acc - ext;
  assign lastStep = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     state_d = SHIFT;
      SHIFT:   state_d = lastStep ? DONE : ADD;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ADD) || (state_q == SHIFT);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      a_q    <= a_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  // Start takes priority over load_b; B is deliberately kept on start so back-to-back multiplies chain.
  always_comb begin
    x_d    = x_q;
    a_d    = a_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d    = 1'b0;
          a_d    = '0;
          cnt_d  = '0;
          mode_d = signed_en;
        end else if (load_b) begin
          b_d = S;
          x_d = 1'b0;
          a_d = '0;
        end
      end
      ADD: begin
        if (b_q[0]) begin
          {x_d, a_d} = (mode_q && lastStep) ? diff : sum;
        end
      end
      SHIFT: begin
        x_d   = mode_q ? x_q : 1'b0;
        a_d   = {x_q, a_q[WIDTH-1:1]};
        b_d   = {a_q[0], b_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
      end
      DONE: begin
        if (load_b) begin
          b_d = S;
          x_d = 1'b0;
          a_d = '0;
        end
      end
      default: begin
        x_d = 1'b0;
      end
    endcase
  end

  assign X = x_q;
  assign A = a_q;
  assign B = b_q;

endmodule

// File: tb/tb_mult_seq_param.sv
// Self-checking bench for mult_seq_param: table-driven vectors through a scoreboard,
// plus hand-written sequences for held start, load_b corners, async reset and a 16-bit build.
module tb_mult_seq_param;
  localparam int W   = 8;
  localparam int W16 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [W-1:0] S;
  logic         loadB, start, signedEn;
  logic         X, busy, done;
  logic [W-1:0] A, B;

  logic [W16-1:0] s16;
  logic           loadB16, start16, signed16;
  logic           x16, busy16, done16;
  logic [W16-1:0] a16, b16;

  mult_seq_param #(.WIDTH(W)) u_dut (
    .clk(clk), .reset(reset), .S(S), .load_b(loadB), .start(start), .signed_en(signedEn),
    .X(X), .A(A), .B(B), .busy(busy), .done(done)
  );

  mult_seq_param #(.WIDTH(W16)) u_dut16 (
    .clk(clk), .reset(reset), .S(s16), .load_b(loadB16), .start(start16), .signed_en(signed16),
    .X(x16), .A(a16), .B(b16), .busy(busy16), .done(done16)
  );

  typedef struct {
    logic [W-1:0] bVal;
    logic [W-1:0] sVal;
    logic         sgn;
    logic [W-1:0] expA;
    logic [W-1:0] expB;
    logic         expX;
  } vec_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         x;
  } exp_t;

  exp_t sbQueue[$];
  int   nCompared   = 0;
  int   nMismatched = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] bv, input logic [W-1:0] sv, input logic sgn);
    longint ib, isv, p;
    exp_t   e;
    ib  = longint'(bv);
    isv = longint'(sv);
    if (sgn) begin
      if (bv[W-1]) ib  -= (longint'(1) << W);
      if (sv[W-1]) isv -= (longint'(1) << W);
    end
    p   = ib * isv;
    e.a = p[2*W-1:W];
    e.b = p[W-1:0];
    e.x = sgn && (p < 0);
    return e;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] bv, input logic [W-1:0] sv, input logic sgn,
                               input exp_t e, input bit doPush);
    @(negedge clk);
    S     = bv;
    loadB = 1'b1;
    @(negedge clk);
    loadB    = 1'b0;
    S        = sv;
    signedEn = sgn;
    start    = 1'b1;
    if (doPush) sbQueue.push_back(e);
  endtask

  task automatic checkOutput(input string name, input bit holdStart);
    int   cycles = 0;
    exp_t e;
    do begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (!holdStart) start = 1'b0;
    end while (!done && cycles < 60);
    checkVal({name, " latency"}, cycles, 2*W + 1);
    if (sbQueue.size() == 0) begin
      checkVal({name, " scoreboard entry"}, 0, 1);
    end else begin
      e = sbQueue.pop_front();
      checkVal({name, " A"}, A, e.a);
      checkVal({name, " B"}, B, e.b);
      checkVal({name, " X"}, X, e.x);
    end
  endtask

  vec_t vecs[$];

  initial begin
    exp_t e;
    int   firstDone, busyAfterDone, cycles;

    reset = 1'b1; S = '0; loadB = 1'b0; start = 1'b0; signedEn = 1'b0;
    s16 = '0; loadB16 = 1'b0; start16 = 1'b0; signed16 = 1'b0;

    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 8'h01, 1'b0});
    vecs.push_back('{8'h3B, 8'hF9, 1'b1, 8'hFE, 8'h63, 1'b1});
    vecs.push_back('{8'hF9, 8'h3B, 1'b1, 8'hFE, 8'h63, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b1, 8'h40, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 8'h00, 8'h01, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h40, 8'h00, 1'b0});
    vecs.push_back('{8'h7F, 8'h80, 1'b1, 8'hC0, 8'h80, 1'b1});
    vecs.push_back('{8'h00, 8'h5A, 1'b1, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{8'h05, 8'h03, 1'b0, 8'h00, 8'h0F, 1'b0});
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v.bVal = W'($urandom_range(0, 255));
      v.sVal = W'($urandom_range(0, 255));
      v.sgn  = 1'($urandom_range(0, 1));
      e      = model(v.bVal, v.sVal, v.sgn);
      v.expA = e.a; v.expB = e.b; v.expX = e.x;
      vecs.push_back(v);
    end

    #12;
    checkVal("reset X", X, 0);
    checkVal("reset A", A, 0);
    checkVal("reset B", B, 0);
    checkVal("reset busy", busy, 0);
    checkVal("reset done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      e.a = vecs[i].expA; e.b = vecs[i].expB; e.x = vecs[i].expX;
      applyStimulus(vecs[i].bVal, vecs[i].sVal, vecs[i].sgn, e, 1'b1);
      checkOutput($sformatf("vec%0d", i), 1'b0);
    end

    // Start held for 40 cycles with a load_b pulse while busy.
    applyStimulus(8'h0D, 8'h0B, 1'b0, model(8'h0D, 8'h0B, 1'b0), 1'b1);
    firstDone = 0;
    busyAfterDone = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 3) loadB = 1'b1;
      if (c == 5) loadB = 1'b0;
      if (done && firstDone == 0) firstDone = c;
      if (firstDone != 0 && busy) busyAfterDone = 1;
    end
    checkVal("held latency", firstDone, 2*W + 1);
    checkVal("held no retrigger", busyAfterDone, 0);
    checkVal("held done", done, 1);
    e = sbQueue.pop_front();
    checkVal("held A", A, e.a);
    checkVal("held B", B, e.b);
    checkVal("held X", X, e.x);

    S = 8'h12;
    loadB = 1'b1;
    @(posedge clk);
    @(negedge clk);
    loadB = 1'b0;
    checkVal("done load B", B, 8'h12);
    checkVal("done load A", A, 0);
    checkVal("done load X", X, 0);
    checkVal("done load stays done", done, 1);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkVal("release done", done, 0);
    checkVal("release busy", busy, 0);

    S = 8'h03;
    signedEn = 1'b0;
    start = 1'b1;
    e.a = 8'h00; e.b = 8'h36; e.x = 1'b0;
    sbQueue.push_back(e);
    checkOutput("back-to-back", 1'b0);

    // Asynchronous reset in the middle of a multiply.
    applyStimulus(8'hFF, 8'hFF, 1'b0, e, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    checkVal("pre-reset busy", busy, 1);
    #1 reset = 1'b1;
    #1;
    checkVal("async reset X", X, 0);
    checkVal("async reset A", A, 0);
    checkVal("async reset B", B, 0);
    checkVal("async reset busy", busy, 0);
    checkVal("async reset done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkVal("post-reset idle", busy, 0);

    // 16-bit instance, signed.
    s16 = 16'h8000;
    loadB16 = 1'b1;
    @(negedge clk);
    loadB16 = 1'b0;
    s16 = 16'h0003;
    signed16 = 1'b1;
    start16 = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      start16 = 1'b0;
    end while (!done16 && cycles < 100);
    checkVal("w16 latency", cycles, 2*W16 + 1);
    checkVal("w16 product", {a16, b16}, 32'hFFFE8000);
    checkVal("w16 X", x16, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  always @(negedge clk) begin
    if (!reset && busy && done) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL busy/done exclusive: got busy=1 done=1, expected at most one");
    end
  end

endmodule
